uart_rxer: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 34 +++
 rtl/uart_rxer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Constants shared by the UART receiver and transmitter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_BAUD_DIV = 5000;
    localparam int UART_DATA_W   = 8;
    localparam int UART_ST_W     = 3;

    localparam logic [UART_ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [UART_ST_W-1:0] S_START = 3'd1;
    localparam logic [UART_ST_W-1:0] S_DATA  = 3'd2;
    localparam logic [UART_ST_W-1:0] S_STOP  = 3'd3;
    localparam logic [UART_ST_W-1:0] S_BREAK = 3'd4;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module  : uart_sync2
// Purpose : Two-flop synchronizer with asynchronous reset to RESET_VAL.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic res,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rxer.sv
// ============================================================================
// Module  : uart_rxer
// Purpose : 8N1 UART receiver, mid-bit sampling, byte out with valid strobe.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rxer
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   RX,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   en_data_out,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int             CON_W    = $clog2(BAUD_DIV);
    localparam logic [CON_W-1:0] CON_HALF = CON_W'(BAUD_DIV / 2 - 1);
    localparam logic [CON_W-1:0] CON_LAST = CON_W'(BAUD_DIV - 1);
    localparam logic [CON_W-1:0] CON_ONE  = CON_W'(1);

    logic rx_s;

    logic [UART_ST_W-1:0]   state_q, state_d;
    logic [CON_W-1:0]       con_q, con_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   en_q, en_d;
    logic                   ferr_q, ferr_d;
    logic                   armed_q, armed_d;
    logic [1:0]             fill_q, fill_d;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .res (res),
        .d_i (RX),
        .q_o (rx_s)
    );

    // The synchronizer resets to 1, so rx_s only reflects the real line once
    // both flops have been refilled; arming before that would let a line held
    // low through reset look like a start bit.
    always_comb begin
        state_d = state_q;
        con_d   = con_q + CON_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = 1'b0;
        ferr_d  = 1'b0;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & rx_s);

        case (state_q)
            S_IDLE: begin
                con_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (con_q == CON_HALF) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (con_q == CON_LAST) begin
                    shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    con_d   = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (con_q == CON_LAST) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        en_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                con_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            con_d = '0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            con_q <= '0;
        end else begin
            con_q <= con_d;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

    assign data_out    = data_q;
    assign en_data_out = en_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire
